// File: rtl/clk_mon.sv
// -----------------------------------------------------------------------------
// clk_mon -- divided-clock frequency monitor
//
// Measures the period of an asynchronous divided clock (div_clk) in cycles of
// the system clock (clk_in). It reports each measured period, declares lock
// after LOCK_COUNT consecutive in-tolerance periods, and raises a sticky fault
// on any out-of-tolerance period or when div_clk stops toggling once
// measurement has started.
//
// Parameters
//   DIV        expected div_clk period in clk_in cycles
//   TOL        allowed deviation from DIV in clk_in cycles
//   LOCK_COUNT consecutive good periods needed for lock (1..15)
//   Legal values: 2*DIV+TOL < 255, DIV > TOL.
//
// Ports
//   clk_in       in   1  system clock, all logic on its rising edge
//   reset        in   1  synchronous active-high reset
//   div_clk      in   1  monitored clock, asynchronous to clk_in
//   period       out  8  last measured div_clk period (clk_in cycles)
//   period_valid out  1  one-cycle pulse when period updates
//   locked       out  1  high while in the LOCKED state
//   fault        out  1  sticky bad-period / timeout flag, cleared by reset
//   dbg_state    out  2  FSM state (0 IDLE, 1 MEASURE, 2 LOCKED)
//
// Handshake: period_valid is a strobe with no back-pressure; period, locked
// and fault are all registered in the same update that raises period_valid,
// so a consumer sampling on the pulse sees a consistent snapshot.
// -----------------------------------------------------------------------------
module clk_mon #(
  parameter int DIV        = 12,
  parameter int TOL        = 1,
  parameter int LOCK_COUNT = 4
) (
  input  logic       clk_in,
  input  logic       reset,
  input  logic       div_clk,
  output logic [7:0] period,
  output logic       period_valid,
  output logic       locked,
  output logic       fault,
  output logic [1:0] dbg_state
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_MEASURE = 2'd1,
    ST_LOCKED  = 2'd2
  } state_t;

  localparam logic [7:0] LP_LO   = 8'(DIV - TOL);
  localparam logic [7:0] LP_HI   = 8'(DIV + TOL);
  localparam logic [7:0] LP_TMO  = 8'(2 * DIV);
  localparam logic [3:0] LP_LOCK = 4'(LOCK_COUNT);

  state_t     r_state;
  logic       r_s1;
  logic       r_s2;
  logic       r_s3;
  logic [7:0] r_cnt;
  logic [3:0] r_good_cnt;
  logic [7:0] r_period;
  logic       r_period_valid;
  logic       r_locked;
  logic       r_fault;

  logic       w_rise;
  logic       w_active;
  logic [7:0] w_period_next;
  logic       w_good;
  logic [3:0] w_good_next;
  logic       w_timeout;

  // r_s1/r_s2 form the synchronizer; r_s3 only remembers the previous
  // synchronized level so a rising edge lasts exactly one clk_in cycle.
  assign w_rise   = r_s2 & ~r_s3;
  assign w_active = (r_state != ST_IDLE);

  // cnt is cleared on the rise cycle, so on the next rise it holds P-1.
  assign w_period_next = (r_cnt == 8'hFF) ? 8'hFF : (r_cnt + 8'd1);
  assign w_good        = (w_period_next >= LP_LO) && (w_period_next <= LP_HI);
  assign w_good_next   = (r_good_cnt >= LP_LOCK) ? LP_LOCK : (r_good_cnt + 4'd1);

  // A rise landing in the same cycle as the threshold wins, so a period of
  // exactly 2*DIV+1 is still measured (and judged bad) rather than timed out.
  assign w_timeout = w_active && !w_rise && (r_cnt == LP_TMO);

  always_ff @(posedge clk_in) begin
    if (reset) begin
      r_s1           <= 1'b0;
      r_s2           <= 1'b0;
      r_s3           <= 1'b0;
      r_cnt          <= 8'd0;
      r_good_cnt     <= 4'd0;
      r_period       <= 8'd0;
      r_period_valid <= 1'b0;
      r_locked       <= 1'b0;
      r_fault        <= 1'b0;
      r_state        <= ST_IDLE;
    end else begin
      r_s1 <= div_clk;
      r_s2 <= r_s1;
      r_s3 <= r_s2;

      if (w_rise) begin
        r_cnt <= 8'd0;
      end else if (r_cnt != 8'hFF) begin
        r_cnt <= r_cnt + 8'd1;
      end

      r_period_valid <= 1'b0;

      case (r_state)
        ST_IDLE: begin
          // First edge only arms measurement; there is no prior edge to
          // measure from, so no period is reported.
          if (w_rise) begin
            r_state    <= ST_MEASURE;
            r_good_cnt <= 4'd0;
          end
        end

        ST_MEASURE, ST_LOCKED: begin
          if (w_rise) begin
            r_period       <= w_period_next;
            r_period_valid <= 1'b1;
            if (w_good) begin
              r_good_cnt <= w_good_next;
              if (w_good_next == LP_LOCK) begin
                r_state  <= ST_LOCKED;
                r_locked <= 1'b1;
              end
            end else begin
              r_good_cnt <= 4'd0;
              r_fault    <= 1'b1;
              r_state    <= ST_MEASURE;
              r_locked   <= 1'b0;
            end
          end else if (w_timeout) begin
            r_fault    <= 1'b1;
            r_locked   <= 1'b0;
            r_good_cnt <= 4'd0;
            r_state    <= ST_IDLE;
          end
        end

        default: begin
          r_state    <= ST_IDLE;
          r_locked   <= 1'b0;
          r_good_cnt <= 4'd0;
        end
      endcase
    end
  end

  assign period       = r_period;
  assign period_valid = r_period_valid;
  assign locked       = r_locked;
  assign fault        = r_fault;
  assign dbg_state    = r_state;

endmodule
